// File: rtl/seg7_scan_display_if.sv
// Source/display bundle for the multiplexed seven-segment driver.
// master drives the sources and observes the digit lines.
interface seg7_scan_display_if;
   logic [2:0]  sel;
   logic [31:0] hex;
   logic [10:0] cnt_clk;
   logic [10:0] cnt_i;
   logic [10:0] cnt_r;
   logic [10:0] cnt_j;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   modport master (
      output sel, hex, cnt_clk, cnt_i, cnt_r, cnt_j,
      input  an, seg, dp, frame_done
   );

   modport slave (
      input  sel, hex, cnt_clk, cnt_i, cnt_r, cnt_j,
      output an, seg, dp, frame_done
   );
endinterface

// File: rtl/seg7_scan_display.sv
// Eight-digit scanned seven-segment driver: per-frame snapshot,
// sequential double-dabble for counters, active-low outputs.
module seg7_scan_display #(
   parameter int SCAN_DIV = 50000,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   seg7_scan_display_if.slave io
);
   localparam int PW = $clog2(SCAN_DIV);

   typedef enum logic [1:0] {
      S_IDLE, S_CONV, S_COMMIT
   } state_e;

   typedef enum logic [1:0] {
      M_HEX, M_DEC, M_DASH
   } mode_e;

   logic [PW-1:0] presc_q, presc_d;
   logic [2:0]    d_q, d_d;
   state_e        state_q, state_d;
   mode_e         mode_q, mode_d;
   mode_e         pmode_q, pmode_d;
   logic [31:0]   dbuf_q, dbuf_d;
   logic [31:0]   snap_q, snap_d;
   logic [10:0]   bin_q, bin_d;
   logic [15:0]   bcd_q, bcd_d;
   logic [3:0]    it_q, it_d;
   logic [7:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          fd_q, fd_d;

   logic          tick;
   logic          capture;
   logic [10:0]   src_cnt;
   logic [15:0]   bcd_adj;
   logic [3:0]    nib;
   logic [31:0]   upper;
   logic          blank;

   function automatic logic [6:0] hex2seg(
      input logic [3:0] v
   );
      hex2seg = 7'h7F;
      unique case (v)
         4'h0: hex2seg = 7'b1000000;
         4'h1: hex2seg = 7'b1111001;
         4'h2: hex2seg = 7'b0100100;
         4'h3: hex2seg = 7'b0110000;
         4'h4: hex2seg = 7'b0011001;
         4'h5: hex2seg = 7'b0010010;
         4'h6: hex2seg = 7'b0000010;
         4'h7: hex2seg = 7'b1111000;
         4'h8: hex2seg = 7'b0000000;
         4'h9: hex2seg = 7'b0010000;
         4'hA: hex2seg = 7'b0001000;
         4'hB: hex2seg = 7'b0000011;
         4'hC: hex2seg = 7'b1000110;
         4'hD: hex2seg = 7'b0100001;
         4'hE: hex2seg = 7'b0000110;
         4'hF: hex2seg = 7'b0001110;
      endcase
   endfunction

   always_comb begin
      tick    = (presc_q == PW'(SCAN_DIV - 1));
      capture = tick && (d_q == 3'd6);
      presc_d = tick ? '0 : presc_q + 1'b1;
      d_d     = tick ? d_q + 3'd1 : d_q;

      src_cnt = io.cnt_j;
      case (io.sel)
         3'd1:    src_cnt = io.cnt_clk;
         3'd2:    src_cnt = io.cnt_i;
         3'd3:    src_cnt = io.cnt_r;
         default: src_cnt = io.cnt_j;
      endcase

      bcd_adj = bcd_q;
      for (int i = 0; i < 4; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end

      state_d = state_q;
      mode_d  = mode_q;
      pmode_d = pmode_q;
      dbuf_d  = dbuf_q;
      snap_d  = snap_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      it_d    = it_q;
      fd_d    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (capture) begin
               snap_d = io.hex;
               bin_d  = src_cnt;
               bcd_d  = '0;
               it_d   = '0;
               if (io.sel == 3'd0) begin
                  pmode_d = M_HEX;
                  state_d = S_COMMIT;
               end else if (io.sel <= 3'd4) begin
                  pmode_d = M_DEC;
                  state_d = S_CONV;
               end else begin
                  pmode_d = M_DASH;
                  state_d = S_COMMIT;
               end
            end
         end
         S_CONV: begin
            {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
            it_d = it_q + 4'd1;
            if (it_q == 4'd10)
               state_d = S_COMMIT;
         end
         S_COMMIT: begin
            mode_d  = pmode_q;
            fd_d    = 1'b1;
            state_d = S_IDLE;
            unique case (pmode_q)
               M_HEX:   dbuf_d = snap_q;
               M_DEC:   dbuf_d = {16'h0, bcd_q};
               default: dbuf_d = '0;
            endcase
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are prepared for the digit the tick is about to select.
      nib   = dbuf_q[{d_d, 2'b00} +: 4];
      upper = dbuf_q >> {d_d, 2'b00};
      blank = 1'b0;
      if (mode_q == M_DEC && d_d[2])
         blank = 1'b1;
      if (BLANK_LZ && mode_q != M_DASH &&
          d_d != 3'd0 && upper == 32'h0)
         blank = 1'b1;

      an_d  = an_q;
      seg_d = seg_q;
      if (tick) begin
         an_d = ~(8'd1 << d_d);
         if (mode_q == M_DASH)
            seg_d = 7'b0111111;
         else if (blank)
            seg_d = 7'h7F;
         else
            seg_d = hex2seg(nib);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= '0;
         d_q     <= '0;
         state_q <= S_IDLE;
         mode_q  <= M_HEX;
         pmode_q <= M_HEX;
         dbuf_q  <= '0;
         snap_q  <= '0;
         bin_q   <= '0;
         bcd_q   <= '0;
         it_q    <= '0;
         an_q    <= 8'hFF;
         seg_q   <= 7'h7F;
         fd_q    <= 1'b0;
      end else begin
         presc_q <= presc_d;
         d_q     <= d_d;
         state_q <= state_d;
         mode_q  <= mode_d;
         pmode_q <= pmode_d;
         dbuf_q  <= dbuf_d;
         snap_q  <= snap_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         it_q    <= it_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         fd_q    <= fd_d;
      end
   end

   assign io.an         = an_q;
   assign io.seg        = seg_q;
   assign io.dp         = 1'b1;
   assign io.frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with SCAN_DIV=16,
// plus a second instance with leading-zero blanking disabled.
module tb_seg7_scan_display;
   logic clk = 1'b0;
   logic reset_n;
   int   n_chk;
   int   n_pass;
   int   n;
   int   m;
   logic [7:0]  prev;
   logic [7:0]  w;
   logic [55:0] ex;

   seg7_scan_display_if io();
   seg7_scan_display_if nb();

   seg7_scan_display #(
      .SCAN_DIV(16)
   ) u_dut (
      .clk    (clk),
      .reset_n(reset_n),
      .io     (io.slave)
   );

   seg7_scan_display #(
      .SCAN_DIV(16),
      .BLANK_LZ(1'b0)
   ) u_nb (
      .clk    (clk),
      .reset_n(reset_n),
      .io     (nb.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h, expected %h",
                  tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_an(
      input bit         alt,
      input logic [7:0] want
   );
      int k;
      k = 0;
      while ((alt ? nb.an : io.an) !== want && k < 300) begin
         step();
         k++;
      end
      if (k >= 300)
         chk("an_timeout", alt ? nb.an : io.an, want);
   endtask

   task automatic wait_fd(output int cnt);
      cnt = 0;
      do begin
         step();
         cnt++;
      end while (io.frame_done !== 1'b1 && cnt < 300);
      if (cnt >= 300)
         chk("fd_timeout", io.frame_done, 1);
   endtask

   task automatic sync_capture();
      wait_an(1'b0, 8'hBF);
      wait_an(1'b0, 8'h7F);
   endtask

   task automatic show_digits(
      input string       tag,
      input logic [55:0] e
   );
      logic [7:0] an_w;
      for (int k = 0; k < 8; k++) begin
         an_w = ~(8'd1 << k);
         wait_an(1'b0, an_w);
         chk($sformatf("%s_d%0d", tag, k),
             io.seg, e[7*k +: 7]);
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: no finish");
      $fatal(1);
   end

   initial begin
      n_chk      = 0;
      n_pass     = 0;
      reset_n    = 1'b0;
      io.sel     = 3'd0;
      io.hex     = 32'h0000_00A5;
      io.cnt_clk = '0;
      io.cnt_i   = '0;
      io.cnt_r   = '0;
      io.cnt_j   = '0;
      nb.sel     = 3'd0;
      nb.hex     = 32'h0;
      nb.cnt_clk = '0;
      nb.cnt_i   = '0;
      nb.cnt_r   = '0;
      nb.cnt_j   = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_an", io.an, 8'hFF);
      chk("rst_seg", io.seg, 7'h7F);
      chk("rst_dp", io.dp, 1);
      chk("rst_fd", io.frame_done, 0);

      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         step();
         chk($sformatf("hold_an_%0d", i), io.an, 8'hFF);
      end
      step();
      chk("tick1_an", io.an, 8'hFD);
      chk("tick1_seg", io.seg, 7'h7F);

      sync_capture();
      wait_fd(n);
      chk("hexA5_lat", n, 1);
      ex = {{6{7'h7F}}, 7'h08, 7'h12};
      show_digits("hexA5", ex);

      io.sel     = 3'd1;
      io.cnt_clk = 11'd2047;
      sync_capture();
      wait_fd(n);
      chk("dec2047_lat", n, 12);
      step();
      chk("fd_pulse", io.frame_done, 0);
      ex = {{4{7'h7F}}, 7'h24, 7'h40, 7'h19, 7'h78};
      show_digits("dec2047", ex);

      io.sel = 3'd0;
      io.hex = 32'h1234_5678;
      sync_capture();
      wait_fd(n);
      chk("hex1234_lat", n, 1);
      ex = {7'h79, 7'h24, 7'h30, 7'h19,
            7'h12, 7'h02, 7'h78, 7'h00};
      for (int k = 0; k < 8; k++) begin
         w = ~(8'd1 << k);
         wait_an(1'b0, w);
         chk($sformatf("hold1234_d%0d", k),
             io.seg, ex[7*k +: 7]);
         if (k == 3)
            io.hex = 32'hDEAD_BEEF;
      end
      wait_fd(n);
      chk("dead_lat", n, 1);
      ex = {7'h21, 7'h06, 7'h08, 7'h21,
            7'h03, 7'h06, 7'h06, 7'h0E};
      show_digits("deadbeef", ex);

      io.sel = 3'd6;
      sync_capture();
      wait_fd(n);
      chk("dash_lat", n, 1);
      for (int i = 0; i < 9; i++) begin
         prev = io.an;
         m = 0;
         while (io.an === prev && m < 40) begin
            step();
            m++;
         end
         w = ~(8'd1 << (i % 8));
         chk($sformatf("dash_an_%0d", i), io.an, w);
         chk($sformatf("dash_seg_%0d", i), io.seg, 7'h3F);
         if (i > 0)
            chk($sformatf("dash_per_%0d", i), m, 16);
      end

      io.sel     = 3'd1;
      io.cnt_clk = 11'd5;
      sync_capture();
      repeat (5) step();
      reset_n = 1'b0;
      #1;
      chk("mid_rst_an", io.an, 8'hFF);
      chk("mid_rst_seg", io.seg, 7'h7F);
      chk("mid_rst_fd", io.frame_done, 0);
      io.cnt_clk = 11'd305;
      @(negedge clk);
      reset_n = 1'b1;
      wait_fd(n);
      chk("rel_lat", n, 124);
      ex = {{5{7'h7F}}, 7'h30, 7'h40, 7'h12};
      show_digits("dec305", ex);

      io.sel   = 3'd2;
      io.cnt_i = 11'd0;
      sync_capture();
      wait_fd(n);
      chk("dec0_lat", n, 12);
      ex = {{7{7'h7F}}, 7'h40};
      show_digits("dec0", ex);

      for (int k = 0; k < 8; k++) begin
         w = ~(8'd1 << k);
         wait_an(1'b1, w);
         chk($sformatf("nolz_d%0d", k), nb.seg, 7'h40);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
